vector_perm_unit: RTL and testbench

Cross-lane permutation responder for the vector datapath. Every lane ALU drives a permutation request (slide-up, slide-down, gather or compress flags, plus source, index and scalar operands and mask). This block accepts the requests of all lanes together as one vector-wide request and processes it one destination element per cycle. It then returns each lane's `lane_perm_result` slice. It is the serving end of the lanes' `lane_perm_*` interface and lives beside the lane array in the vector execution stage.

---
 rtl/vperm_pkg.sv | 36 +++
 rtl/vperm_elem_sel.sv | 21 ++
 rtl/vector_perm_unit.sv | 193 +++++++++++++++++++
 tb/tb_vector_perm_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vperm_pkg.sv
// Shared types and helpers for the cross-lane permutation unit.
package vperm_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    typedef enum logic [2:0] {SLIDEUP, SLIDEDOWN, GATHER, COMPRESS, ILLEGAL} op_e;

    // Element count for the whole vector; element width is 8 << sew bits.
    function automatic int unsigned num_elems(input logic [1:0] sew,
                                              input int unsigned lanes,
                                              input int unsigned width);
        return (lanes * width) >> (3 + int'(sew));
    endfunction

    function automatic logic [63:0] sew_mask(input logic [1:0] sew);
        case (sew)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Exactly one flag selects an op; anything else is rejected.
    function automatic op_e decode_op(input logic up, input logic down,
                                      input logic group, input logic gather);
        case ({up, down, group, gather})
            4'b1000: return SLIDEUP;
            4'b0100: return SLIDEDOWN;
            4'b0010: return COMPRESS;
            4'b0001: return GATHER;
            default: return ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/vperm_elem_sel.sv
// Extracts one element of a flattened lane vector, zero-extended to 64 bits.
// Lanes are packed back to back, so element e always starts at bit e * SEW.
module vperm_elem_sel #(
    parameter int TW   = 512,
    parameter int IDXW = 7
) (
    input  logic [TW-1:0]   vec_i,
    input  logic [1:0]      sew_i,
    input  logic [IDXW-1:0] idx_i,
    output logic [63:0]     elem_o
);
    import vperm_pkg::*;

    logic [IDXW+2:0] bitOffset;
    logic [63:0]     lowBits;

    assign bitOffset = {idx_i, 3'b000} << sew_i;
    assign lowBits   = 64'(vec_i >> bitOffset);
    assign elem_o    = lowBits & sew_mask(sew_i);

endmodule

// File: rtl/vector_perm_unit.sv
// Cross-lane permutation responder: takes one vector-wide request from the lane
// array and builds the permuted result one destination element per cycle.
module vector_perm_unit #(
    parameter int VECTOR_LANES = 8,
    parameter int DATA_WIDTH   = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [2:0]                         sew,
    input  logic [VECTOR_LANES-1:0]            lane_perm_slideup,
    input  logic [VECTOR_LANES-1:0]            lane_perm_slidedown,
    input  logic [VECTOR_LANES-1:0]            lane_perm_group,
    input  logic [VECTOR_LANES-1:0]            lane_perm_gather,
    input  logic [VECTOR_LANES*DATA_WIDTH-1:0] lane_perm_input,
    input  logic [VECTOR_LANES*DATA_WIDTH-1:0] lane_perm_vector,
    input  logic [VECTOR_LANES*DATA_WIDTH-1:0] lane_perm_scalar,
    input  logic [VECTOR_LANES*(DATA_WIDTH/8)-1:0] lane_perm_mask,
    output logic [VECTOR_LANES*DATA_WIDTH-1:0] lane_perm_result,
    output logic                               resp_valid,
    output logic                               resp_err
);
    import vperm_pkg::*;

    localparam int TW   = VECTOR_LANES * DATA_WIDTH;
    localparam int MW   = VECTOR_LANES * (DATA_WIDTH / 8);
    localparam int MBW  = $clog2(DATA_WIDTH / 8);
    localparam int IDXW = $clog2(MW) + 1;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [1:0]          sew_q, sew_d;
    logic [DATA_WIDTH-1:0] off_q, off_d;
    logic [TW-1:0]       src_q, src_d, vec_q, vec_d;
    logic [MW-1:0]       mask_q, mask_d;
    logic [TW-1:0]       buf_q, buf_d, result_q, result_d;
    logic [IDXW-1:0]     i_q, i_d, wptr_q, wptr_d;

    logic [IDXW-1:0]     nElems, lastIdx, srcIdx, dstIdx, eplShift, maskIdx;
    logic [63:0]         srcElem, gatherIdx;
    logic [DATA_WIDTH:0] iExt, sum;
    logic                srcOk, maskBit;
    logic [IDXW+2:0]     dstSh;
    logic [TW-1:0]       elemMask, wrData;
    logic                unusedInputs;

    assign unusedInputs = ^{sew[2], lane_perm_slideup[VECTOR_LANES-1:1],
                            lane_perm_slidedown[VECTOR_LANES-1:1],
                            lane_perm_group[VECTOR_LANES-1:1],
                            lane_perm_gather[VECTOR_LANES-1:1],
                            lane_perm_scalar[TW-1:DATA_WIDTH]};

    assign nElems  = IDXW'(num_elems(sew_q, VECTOR_LANES, DATA_WIDTH));
    assign lastIdx = nElems - IDXW'(1);

    // Mask bits are laid out per lane with a fixed DATA_WIDTH/8 stride,
    // so the global element index is split into lane and in-lane position.
    assign eplShift = IDXW'(MBW) - IDXW'(sew_q);
    assign maskIdx  = ((i_q >> eplShift) << MBW) | (i_q & ~({IDXW{1'b1}} << eplShift));
    assign maskBit  = 1'(mask_q >> maskIdx);

    vperm_elem_sel #(.TW(TW), .IDXW(IDXW)) uSrcSel (
        .vec_i  (src_q),
        .sew_i  (sew_q),
        .idx_i  (srcIdx),
        .elem_o (srcElem)
    );

    vperm_elem_sel #(.TW(TW), .IDXW(IDXW)) uIdxSel (
        .vec_i  (vec_q),
        .sew_i  (sew_q),
        .idx_i  (i_q),
        .elem_o (gatherIdx)
    );

    // Offsets and gather indices are compared at full width so huge values
    // select zero instead of wrapping into the vector.
    always_comb begin
        srcIdx = i_q;
        dstIdx = i_q;
        srcOk  = 1'b0;
        iExt   = (DATA_WIDTH+1)'(i_q);
        sum    = iExt + {1'b0, off_q};
        case (op_q)
            SLIDEUP: begin
                srcOk  = iExt >= {1'b0, off_q};
                srcIdx = i_q - off_q[IDXW-1:0];
            end
            SLIDEDOWN: begin
                srcOk  = sum < (DATA_WIDTH+1)'(nElems);
                srcIdx = sum[IDXW-1:0];
            end
            GATHER: begin
                srcOk  = gatherIdx < 64'(nElems);
                srcIdx = gatherIdx[IDXW-1:0];
            end
            COMPRESS: begin
                srcOk  = maskBit;
                dstIdx = wptr_q;
            end
            default: srcOk = 1'b0;
        endcase
    end

    assign dstSh    = {dstIdx, 3'b000} << sew_q;
    assign elemMask = TW'(sew_mask(sew_q)) << dstSh;
    assign wrData   = TW'(srcElem) << dstSh;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sew_d    = sew_q;
        off_d    = off_q;
        src_d    = src_q;
        vec_d    = vec_q;
        mask_d   = mask_q;
        buf_d    = buf_q;
        i_d      = i_q;
        wptr_d   = wptr_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d   = decode_op(lane_perm_slideup[0], lane_perm_slidedown[0],
                                       lane_perm_group[0], lane_perm_gather[0]);
                    sew_d  = sew[1:0];
                    off_d  = lane_perm_scalar[DATA_WIDTH-1:0];
                    src_d  = lane_perm_input;
                    vec_d  = lane_perm_vector;
                    mask_d = lane_perm_mask;
                    buf_d  = '0;
                    i_d    = '0;
                    wptr_d = '0;
                    if (op_d == ILLEGAL) begin
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (srcOk) begin
                    buf_d = (buf_q & ~elemMask) | wrData;
                    if (op_q == COMPRESS) wptr_d = wptr_q + IDXW'(1);
                end
                i_d = i_q + IDXW'(1);
                // Result is published on entry to DONE so it is valid with resp_valid.
                if (i_q == lastIdx) begin
                    state_d  = DONE;
                    result_d = buf_d;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= ILLEGAL;
            sew_q    <= '0;
            off_q    <= '0;
            src_q    <= '0;
            vec_q    <= '0;
            mask_q   <= '0;
            buf_q    <= '0;
            result_q <= '0;
            i_q      <= '0;
            wptr_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sew_q    <= sew_d;
            off_q    <= off_d;
            src_q    <= src_d;
            vec_q    <= vec_d;
            mask_q   <= mask_d;
            buf_q    <= buf_d;
            result_q <= result_d;
            i_q      <= i_d;
            wptr_q   <= wptr_d;
        end
    end

    assign req_ready        = (state_q == IDLE);
    assign resp_valid       = (state_q == DONE);
    assign resp_err         = (state_q == DONE) && (op_q == ILLEGAL);
    assign lane_perm_result = result_q;

endmodule

// File: tb/tb_vector_perm_unit.sv
// Scoreboard bench for vector_perm_unit with 4 lanes of 64 bits.
module tb_vector_perm_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   sew;
    logic [3:0]   lane_perm_slideup, lane_perm_slidedown, lane_perm_group, lane_perm_gather;
    logic [255:0] lane_perm_input, lane_perm_vector, lane_perm_scalar;
    logic [31:0]  lane_perm_mask;
    logic [255:0] lane_perm_result;
    logic         resp_valid, resp_err;

    typedef struct {
        logic [255:0] result;
        logic         err;
        int           latency;
        int           acceptCycle;
    } expT;

    expT sbQ[$];
    int  compared = 0;
    int  mismatched = 0;
    int  cycleCnt = 0;
    bit  respSeen = 1'b0;

    vector_perm_unit #(.VECTOR_LANES(4), .DATA_WIDTH(64)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .sew                 (sew),
        .lane_perm_slideup   (lane_perm_slideup),
        .lane_perm_slidedown (lane_perm_slidedown),
        .lane_perm_group     (lane_perm_group),
        .lane_perm_gather    (lane_perm_gather),
        .lane_perm_input     (lane_perm_input),
        .lane_perm_vector    (lane_perm_vector),
        .lane_perm_scalar    (lane_perm_scalar),
        .lane_perm_mask      (lane_perm_mask),
        .lane_perm_result    (lane_perm_result),
        .resp_valid          (resp_valid),
        .resp_err            (resp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] elemMask(input int s);
        return (s == 3) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 << s)) - 64'd1);
    endfunction

    // Element e sits in lane e/EPL at position e%EPL.
    function automatic int elemBase(input int e, input int s);
        int epl = 64 / (8 << s);
        return (e / epl) * 64 + (e % epl) * (8 << s);
    endfunction

    function automatic logic [63:0] getElem(input logic [255:0] v, input int e, input int s);
        return 64'(v >> elemBase(e, s)) & elemMask(s);
    endfunction

    function automatic logic [255:0] setElem(input logic [255:0] v, input int e, input int s, input logic [63:0] val);
        return (v & ~(256'(elemMask(s)) << elemBase(e, s))) | (256'(val & elemMask(s)) << elemBase(e, s));
    endfunction

    // Reference permutation; fl = {slideup, slidedown, group, gather}.
    function automatic logic [255:0] modelPerm(input logic [3:0] fl, input int s, input logic [63:0] off,
                                               input logic [255:0] src, input logic [255:0] vec,
                                               input logic [31:0] mask, output logic err);
        logic [255:0] res = '0;
        int n = 4 * (64 / (8 << s));
        int epl = 64 / (8 << s);
        int wp = 0;
        logic [63:0] ix;
        err = ($countones(fl) != 1);
        if (err) return '0;
        for (int i = 0; i < n; i++) begin
            if (fl[3]) begin
                if ({1'b0, off} <= 65'(i)) res = setElem(res, i, s, getElem(src, i - int'(off), s));
            end else if (fl[2]) begin
                if (({1'b0, off} + 65'(i)) < 65'(n)) res = setElem(res, i, s, getElem(src, i + int'(off), s));
            end else if (fl[1]) begin
                if (1'(mask >> ((i / epl) * 8 + (i % epl)))) begin
                    res = setElem(res, wp, s, getElem(src, i, s));
                    wp++;
                end
            end else begin
                ix = getElem(vec, i, s);
                if (ix < 64'(n)) res = setElem(res, i, s, getElem(src, int'(ix), s));
            end
        end
        return res;
    endfunction

    task automatic applyStimulus(input logic [3:0] fl, input int eSew, input logic [63:0] off,
                                 input logic [255:0] src, input logic [255:0] vec,
                                 input logic [31:0] mask, input bit expectResp);
        int  waitCnt = 0;
        expT e;
        @(negedge clk);
        while (!req_ready && waitCnt < 300) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!req_ready) begin
            checkOutput("readyTimeout", 256'(req_ready), 256'd1);
            return;
        end
        sew                 = {1'($urandom), 2'(eSew)};
        lane_perm_slideup   = {3'($urandom), fl[3]};
        lane_perm_slidedown = {3'($urandom), fl[2]};
        lane_perm_group     = {3'($urandom), fl[1]};
        lane_perm_gather    = {3'($urandom), fl[0]};
        lane_perm_input     = src;
        lane_perm_vector    = vec;
        lane_perm_scalar    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, off};
        lane_perm_mask      = mask;
        req_valid           = 1'b1;
        @(posedge clk);
        #1;
        req_valid        = 1'b0;
        sew              = 3'($urandom);
        lane_perm_input  = ~src;
        lane_perm_vector = ~vec;
        lane_perm_mask   = ~mask;
        if (expectResp) begin
            e.result      = modelPerm(fl, eSew, off, src, vec, mask, e.err);
            e.latency     = e.err ? 0 : 4 * (64 / (8 << eSew));
            e.acceptCycle = cycleCnt;
            sbQ.push_back(e);
        end
    endtask

    // Response monitor: pops the scoreboard and checks data, error and latency.
    always @(negedge clk) begin
        expT e;
        if (respSeen) checkOutput("readyAfterDone", 256'(req_ready), 256'd1);
        respSeen = (resp_valid === 1'b1);
        if (resp_valid === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedResp", 256'(resp_valid), 256'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("result", lane_perm_result, e.result);
                checkOutput("respErr", 256'(resp_err), 256'(e.err));
                checkOutput("latency", 256'(cycleCnt - e.acceptCycle), 256'(e.latency));
            end
        end
    end

    initial begin
        logic [255:0] src, vec;
        logic [3:0]   fl;
        int           rs, n, w;
        logic [63:0]  off;

        rst = 1'b1;
        req_valid = 1'b0;
        sew = '0;
        {lane_perm_slideup, lane_perm_slidedown, lane_perm_group, lane_perm_gather} = '0;
        lane_perm_input = '0;
        lane_perm_vector = '0;
        lane_perm_scalar = '0;
        lane_perm_mask = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("resetReady", 256'(req_ready), 256'd1);
        checkOutput("resetRespValid", 256'(resp_valid), 256'd0);
        checkOutput("resetRespErr", 256'(resp_err), 256'd0);
        checkOutput("resetResult", lane_perm_result, 256'd0);

        src = '0;
        for (int k = 0; k < 32; k++) src = setElem(src, k, 0, 64'(k));
        applyStimulus(4'b1000, 0, 64'd3, src, 256'd0, 32'd0, 1'b1);

        src = '0;
        for (int k = 0; k < 8; k++) src = setElem(src, k, 2, 64'(32'h100 + k));
        applyStimulus(4'b0100, 2, 64'd5, src, 256'd0, 32'd0, 1'b1);
        applyStimulus(4'b0100, 2, 64'd1 << 40, src, 256'd0, 32'd0, 1'b1);

        src = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C, 64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
        vec = {64'd1, 64'd9, 64'd0, 64'd3};
        applyStimulus(4'b0001, 3, 64'd0, src, vec, 32'd0, 1'b1);

        src = '0;
        for (int k = 0; k < 32; k++) src = setElem(src, k, 0, 64'(k));
        applyStimulus(4'b0010, 0, 64'd0, src, 256'd0, 32'hAAAA_AAAA, 1'b1);

        applyStimulus(4'b1001, 0, 64'd2, src, 256'd0, 32'd0, 1'b1);
        applyStimulus(4'b0000, 1, 64'd2, src, 256'd0, 32'd0, 1'b1);

        // A second request while busy must not be taken.
        applyStimulus(4'b0100, 2, 64'd1, src, 256'd0, 32'd0, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("readyLowInRun", 256'(req_ready), 256'd0);
        req_valid = 1'b1;
        lane_perm_gather = 4'b0001;
        lane_perm_slideup = 4'b0000;
        lane_perm_slidedown = 4'b0000;
        lane_perm_group = 4'b0000;
        sew = 3'd3;
        repeat (3) @(negedge clk);
        req_valid = 1'b0;

        applyStimulus(4'b1000, 0, 64'd3, src, 256'd0, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abortReady", 256'(req_ready), 256'd1);
        checkOutput("abortResult", lane_perm_result, 256'd0);
        checkOutput("abortRespValid", 256'(resp_valid), 256'd0);
        applyStimulus(4'b1000, 0, 64'd3, src, 256'd0, 32'd0, 1'b1);

        for (int t = 0; t < 12; t++) begin
            rs = $urandom_range(0, 3);
            n = 4 * (64 / (8 << rs));
            w = $urandom_range(0, 9);
            fl = (w < 8) ? (4'b0001 << (w % 4)) : ((w == 8) ? 4'b0000 : 4'b0110);
            off = ($urandom_range(0, 5) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, n + 2));
            src = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            vec = '0;
            for (int k = 0; k < n; k++) vec = setElem(vec, k, rs, 64'($urandom_range(0, n + 3)));
            applyStimulus(fl, rs, off, src, vec, $urandom, 1'b1);
        end

        w = 0;
        while (sbQ.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        checkOutput("drain", 256'(sbQ.size()), 256'd0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
